// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage (port 0) vs program loader (port 1) with loader bursts.
// Define DM_ARB_RR_EN for round-robin tie-breaking; default is CPU priority with a starvation guard.
module dm_port_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic [3:0]        ldr_burst_len,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic {IDLE, LDR_BURST} state_t;

  state_t     state_reg;
  logic [3:0] beat_cnt_reg;
  logic [3:0] first_beats;
  logic       cpu_win;

  // Remaining beats after the first one: zero length counts as one, long requests clamp.
  always_comb begin
    if (ldr_burst_len == 4'd0)
      first_beats = 4'd0;
    else if ({1'b0, ldr_burst_len} > 5'(MAX_BURST))
      first_beats = 4'(MAX_BURST - 1);
    else
      first_beats = ldr_burst_len - 4'd1;
  end

`ifdef DM_ARB_RR_EN
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  logic last_owner_reg;

  assign cpu_win = cpu_req && (!ldr_req || last_owner_reg == OWNER_LDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_owner_reg <= OWNER_LDR;
    else if (cpu_gnt)
      last_owner_reg <= OWNER_CPU;
    else if (ldr_gnt)
      last_owner_reg <= OWNER_LDR;
  end
`else
  logic [2:0] starve_cnt_reg;
  logic       starve_ok;

  assign starve_ok = ({1'b0, starve_cnt_reg} < 4'(STARVE_LIMIT));
  assign cpu_win   = cpu_req && (starve_ok || !ldr_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt_reg <= 3'd0;
    else if (ldr_req && !ldr_gnt) begin
      if (starve_cnt_reg != 3'd7)
        starve_cnt_reg <= starve_cnt_reg + 3'd1;
    end else
      starve_cnt_reg <= 3'd0;
  end
`endif

  // Grants are forced low while reset is asserted so no access leaks through.
  assign cpu_gnt   = rst_n && (state_reg == IDLE) && cpu_win;
  assign ldr_gnt   = rst_n && ldr_req && ((state_reg == LDR_BURST) || !cpu_win);
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign rdata     = dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ldr_gnt) begin
            beat_cnt_reg <= first_beats;
            state_reg    <= (first_beats != 4'd0) ? LDR_BURST : IDLE;
          end
        end
        LDR_BURST: begin
          if (ldr_req) begin
            beat_cnt_reg <= beat_cnt_reg - 4'd1;
            if (beat_cnt_reg <= 4'd1)
              state_reg <= IDLE;
          end else begin
            beat_cnt_reg <= 4'd0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          beat_cnt_reg <= 4'd0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_we    = cpu_we;
      dm_re    = !cpu_we;
    end else if (ldr_gnt) begin
      dm_addr  = ldr_addr;
      dm_wdata = ldr_wdata;
      dm_we    = ldr_we;
      dm_re    = !ldr_we;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model and a shadow copy of data memory.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [6:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [6:0]  ldr_addr = '0;
  logic [31:0] ldr_wdata = '0;
  logic [3:0]  ldr_burst_len = '0;
  logic        cpu_gnt, cpu_stall, ldr_gnt, dm_we, dm_re;
  logic [31:0] rdata, dm_wdata, dm_rdata;
  logic [6:0]  dm_addr;

  logic [31:0] dm_mem [128];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: beats still owed to the loader, consecutive loader denials, shadow memory.
  int          burst_left = 0;
  int          denied = 0;
  bit          last_cpu = 1'b0;
  logic [31:0] shadow [128];
  bit          shadow_ok [128];

  dm_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_burst_len(ldr_burst_len), .ldr_gnt(ldr_gnt),
    .rdata(rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dm_we) dm_mem[dm_addr] <= dm_wdata;
  assign dm_rdata = dm_mem[dm_addr];

  logic [43:0] act_vec;
  assign act_vec = {cpu_gnt, ldr_gnt, cpu_stall, dm_we, dm_re, dm_addr, dm_wdata};

  function automatic logic [1:0] pred_gnt();
    logic cw;
    if (!rst_n) return 2'b00;
    if (burst_left > 0) return {1'b0, ldr_req};
`ifdef DM_ARB_RR_EN
    cw = cpu_req && (!ldr_req || !last_cpu);
`else
    cw = cpu_req && (denied < 4 || !ldr_req);
`endif
    return {cw, ldr_req && !cw};
  endfunction

  function automatic logic [43:0] pred_vec();
    logic [1:0]  g;
    logic [6:0]  a;
    logic [31:0] d;
    logic        we, re;
    g = pred_gnt();
    a = '0; d = '0; we = 1'b0; re = 1'b0;
    if (g[1]) begin
      a = cpu_addr; d = cpu_wdata; we = cpu_we; re = !cpu_we;
    end else if (g[0]) begin
      a = ldr_addr; d = ldr_wdata; we = ldr_we; re = !ldr_we;
    end
    return {g, cpu_req && !g[1], we, re, a, d};
  endfunction

  // {known, value}: known only for a granted read of a word the model has seen written.
  function automatic logic [32:0] pred_rdata();
    logic [1:0] g;
    g = pred_gnt();
    if (g[1] && !cpu_we && shadow_ok[cpu_addr]) return {1'b1, shadow[cpu_addr]};
    if (g[0] && !ldr_we && shadow_ok[ldr_addr]) return {1'b1, shadow[ldr_addr]};
    return 33'd0;
  endfunction

  task automatic model_commit();
    logic [1:0] g;
    int eff;
    g = pred_gnt();
    if (g[1]) begin
      $display("txn cpu %s addr=%02h data=%08h", cpu_we ? "wr" : "rd", cpu_addr,
               cpu_we ? cpu_wdata : rdata);
      if (cpu_we) begin shadow[cpu_addr] = cpu_wdata; shadow_ok[cpu_addr] = 1'b1; end
    end
    if (g[0]) begin
      $display("txn ldr %s addr=%02h data=%08h", ldr_we ? "wr" : "rd", ldr_addr,
               ldr_we ? ldr_wdata : rdata);
      if (ldr_we) begin shadow[ldr_addr] = ldr_wdata; shadow_ok[ldr_addr] = 1'b1; end
    end
    if (burst_left > 0)
      burst_left = ldr_req ? burst_left - 1 : 0;
    else if (g[0]) begin
      eff = (ldr_burst_len == 0) ? 1 : ((ldr_burst_len > 8) ? 8 : int'(ldr_burst_len));
      burst_left = eff - 1;
    end
    denied = (ldr_req && !g[0]) ? denied + 1 : 0;
    if (g[1]) last_cpu = 1'b1;
    else if (g[0]) last_cpu = 1'b0;
  endtask

  task automatic model_reset();
    burst_left = 0;
    denied = 0;
    last_cpu = 1'b0;
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_burst_len = '0;
  endtask

  task automatic test_reset();
    logic [43:0] ev;
    rst_n = 1'b0;
    cpu_req = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1; ldr_burst_len = 4'd3;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({cpu_gnt, ldr_gnt, dm_we, dm_re, cpu_stall} !== 5'b00001)
      $display("FAIL reset_outputs got=%b want=00001", {cpu_gnt, ldr_gnt, dm_we, dm_re, cpu_stall});
    else n_pass++;
    set_idle();
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cycle_start();
    @(negedge clk);
    ev = pred_vec();
    n_checks++;
    if (act_vec !== ev) $display("FAIL reset_idle got=%h want=%h", act_vec, ev);
    else n_pass++;
    model_commit();
  endtask

  task automatic test_cpu_write_read();
    logic [43:0] ev;
    logic [32:0] er;
    for (int c = 0; c < 2; c++) begin
      cycle_start();
      cpu_req = 1'b1; cpu_we = (c == 0); cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      ev = pred_vec(); er = pred_rdata();
      n_checks++;
      if (act_vec !== ev) $display("FAIL cpu_rw_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (er[32]) begin
        n_checks++;
        if (rdata !== er[31:0]) $display("FAIL cpu_rw_rdata c=%0d got=%h want=%h", c, rdata, er[31:0]);
        else n_pass++;
      end
      n_checks++;
      if (c == 0 && {cpu_gnt, cpu_stall} !== 2'b10)
        $display("FAIL cpu_same_cycle_gnt got=%b want=10", {cpu_gnt, cpu_stall});
      else if (c == 1 && rdata !== 32'hDEADBEEF)
        $display("FAIL cpu_readback got=%h want=deadbeef", rdata);
      else n_pass++;
      model_commit();
    end
    cycle_start(); set_idle(); @(negedge clk); model_commit();
  endtask

  task automatic test_burst_stall();
    logic [43:0] ev;
    logic [32:0] er;
    int ldr_cnt = 0, cpu_at = -1;
    bit cpu_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle_start();
      ldr_req = (c < 3); ldr_we = 1'b1; ldr_burst_len = 4'd3;
      ldr_addr = 7'h10 + 7'(c); ldr_wdata = $urandom;
      cpu_req = (c >= 1) && !cpu_done; cpu_we = 1'b0; cpu_addr = 7'h10;
      @(negedge clk);
      ev = pred_vec(); er = pred_rdata();
      n_checks++;
      if (act_vec !== ev) $display("FAIL burst_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (er[32]) begin
        n_checks++;
        if (rdata !== er[31:0]) $display("FAIL burst_rdata c=%0d got=%h want=%h", c, rdata, er[31:0]);
        else n_pass++;
      end
      if (ldr_gnt) ldr_cnt++;
      if (cpu_gnt && cpu_at < 0) cpu_at = c;
      if (pred_gnt() & 2'b10) cpu_done = 1'b1;
      model_commit();
    end
    n_checks++;
    if (ldr_cnt != 3 || cpu_at != 3)
      $display("FAIL burst_len3 ldr_beats=%0d cpu_gnt_cycle=%0d want 3 and 3", ldr_cnt, cpu_at);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_starvation();
    logic [43:0] ev;
    logic [32:0] er;
    int ldr_at = -1;
    bit ldr_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle_start();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10 + 7'(c % 3);
      ldr_req = !ldr_done; ldr_we = 1'b0; ldr_addr = 7'h05; ldr_burst_len = 4'd1;
      @(negedge clk);
      ev = pred_vec(); er = pred_rdata();
      n_checks++;
      if (act_vec !== ev) $display("FAIL starve_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (er[32]) begin
        n_checks++;
        if (rdata !== er[31:0]) $display("FAIL starve_rdata c=%0d got=%h want=%h", c, rdata, er[31:0]);
        else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if (cpu_gnt !== 1'b1) $display("FAIL starve_cpu_resume got=%b want=1", cpu_gnt);
        else n_pass++;
      end
      if (ldr_gnt && ldr_at < 0) ldr_at = c;
      if (pred_gnt() & 2'b01) ldr_done = 1'b1;
      model_commit();
    end
`ifndef DM_ARB_RR_EN
    n_checks++;
    if (ldr_at != 4) $display("FAIL starve_ldr_first_gnt got=%0d want=4", ldr_at);
    else n_pass++;
`endif
    set_idle();
  endtask

  task automatic test_burst_abort();
    logic [43:0] ev;
    int ldr_cnt = 0, cpu_at = -1;
    bit cpu_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle_start();
      ldr_req = (c < 2); ldr_we = 1'b1; ldr_burst_len = 4'd5;
      ldr_addr = 7'h20 + 7'(c); ldr_wdata = $urandom;
      cpu_req = (c >= 2) && !cpu_done; cpu_we = 1'b1; cpu_addr = 7'h22; cpu_wdata = $urandom;
      @(negedge clk);
      ev = pred_vec();
      n_checks++;
      if (act_vec !== ev) $display("FAIL abort_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (ldr_gnt) ldr_cnt++;
      if (cpu_gnt && cpu_at < 0) cpu_at = c;
      if (pred_gnt() & 2'b10) cpu_done = 1'b1;
      model_commit();
    end
    n_checks++;
    if (ldr_cnt != 2 || cpu_at != 3)
      $display("FAIL abort_result ldr_beats=%0d cpu_gnt_cycle=%0d want 2 and 3", ldr_cnt, cpu_at);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_len_clamp();
    logic [43:0] ev;
    logic [3:0]  lens [2];
    int          want [2];
    int          ldr_cnt;
    bit          cpu_done;
    lens[0] = 4'd0;  want[0] = 1;
    lens[1] = 4'd15; want[1] = 8;
    for (int t = 0; t < 2; t++) begin
      ldr_cnt = 0; cpu_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
        cycle_start();
        ldr_req = !cpu_done; ldr_we = 1'b1; ldr_burst_len = lens[t];
        ldr_addr = 7'h30 + 7'(c); ldr_wdata = $urandom;
        cpu_req = (c >= 1) && !cpu_done; cpu_we = 1'b0; cpu_addr = 7'h30;
        @(negedge clk);
        ev = pred_vec();
        n_checks++;
        if (act_vec !== ev) $display("FAIL clamp_vec len=%0d c=%0d got=%h want=%h", lens[t], c, act_vec, ev);
        else n_pass++;
        if (ldr_gnt && !cpu_done) ldr_cnt++;
        if (pred_gnt() & 2'b10) cpu_done = 1'b1;
        model_commit();
      end
      n_checks++;
      if (ldr_cnt != want[t]) $display("FAIL clamp_beats len=%0d got=%0d want=%0d", lens[t], ldr_cnt, want[t]);
      else n_pass++;
    end
    set_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic [43:0] ev;
    logic [32:0] er;
    for (int c = 0; c < 3; c++) begin
      cycle_start();
      cpu_req = (c == 0); cpu_we = 1'b1; cpu_addr = 7'h42; cpu_wdata = 32'h11112222;
      ldr_req = (c > 0); ldr_we = 1'b1; ldr_burst_len = 4'd6;
      ldr_addr = 7'h40 + 7'(c - 1); ldr_wdata = $urandom;
      @(negedge clk);
      ev = pred_vec();
      n_checks++;
      if (act_vec !== ev) $display("FAIL rstburst_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      model_commit();
    end
    cycle_start();
    ldr_req = 1'b1; ldr_addr = 7'h42; ldr_wdata = 32'hBADBAD00;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_gnt, ldr_gnt, dm_we, dm_re} !== 4'b0000)
      $display("FAIL rstburst_async got=%b want=0000", {cpu_gnt, ldr_gnt, dm_we, dm_re});
    else n_pass++;
    model_reset();
    set_idle();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle_start();
      cpu_req = (c == 0); cpu_we = 1'b0; cpu_addr = 7'h42;
      ldr_req = (c < 2); ldr_we = 1'b0; ldr_addr = 7'h40; ldr_burst_len = 4'd1;
      @(negedge clk);
      ev = pred_vec(); er = pred_rdata();
      n_checks++;
      if (act_vec !== ev) $display("FAIL rstburst_after c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (c == 0) begin
        n_checks++;
        if (cpu_gnt !== 1'b1 || rdata !== 32'h11112222)
          $display("FAIL rstburst_idle gnt=%b rdata=%h want 1 and 11112222", cpu_gnt, rdata);
        else n_pass++;
      end else if (er[32]) begin
        n_checks++;
        if (rdata !== er[31:0]) $display("FAIL rstburst_rdata c=%0d got=%h want=%h", c, rdata, er[31:0]);
        else n_pass++;
      end
      model_commit();
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [43:0] ev;
    logic [32:0] er;
    logic [1:0]  g;
    bit cp = 1'b0, lp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cycle_start();
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1'b1; cpu_we = $urandom_range(0, 1);
        cpu_addr = 7'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end
      if (!lp && $urandom_range(0, 1) == 0) begin
        lp = 1'b1; ldr_we = $urandom_range(0, 1);
        ldr_addr = 7'($urandom_range(0, 15)); ldr_wdata = $urandom;
        ldr_burst_len = 4'($urandom_range(0, 15));
      end
      cpu_req = cp; ldr_req = lp;
      @(negedge clk);
      ev = pred_vec(); er = pred_rdata();
      n_checks++;
      if (act_vec !== ev) $display("FAIL rand_vec c=%0d got=%h want=%h", c, act_vec, ev);
      else n_pass++;
      if (er[32]) begin
        n_checks++;
        if (rdata !== er[31:0]) $display("FAIL rand_rdata c=%0d got=%h want=%h", c, rdata, er[31:0]);
        else n_pass++;
      end
      g = pred_gnt();
      if (g[1]) cp = 1'b0;
      if (g[0]) lp = 1'b0;
      model_commit();
    end
    set_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write_read();
    test_burst_stall();
    test_starvation();
    test_burst_abort();
    test_len_clamp();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data memory (7-bit word address, 32-bit data, MemWrite/MemRead) between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the program/data loader (DMA).
- Decides one owner per cycle, muxes that owner's address, data and controls onto the DM port, and drives a stall back to the pipeline.
- Supports multi-beat loader bursts and a starvation guard so neither requester is locked out.

Parameters:
- ADDR_W, 7, DM address width.
- DATA_W, 32, DM data width.
- MAX_BURST, 8, maximum loader beats per ownership; longer requests are clamped.
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader wins over the CPU.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU MEM stage wants DM this cycle (MemRead|MemWrite).
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC/IFID/IDEX/EXMEM.
- ldr_req  in  1  loader wants DM.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader word address.
- ldr_wdata  in  DATA_W  loader data.
- ldr_burst_len  in  4  requested beats (0 treated as 1), sampled on first grant.
- ldr_gnt  out  1  loader access performed this cycle.
- rdata  out  DATA_W  DM read data, passthrough; valid for whichever gnt is high.
- dm_addr  out  ADDR_W  to DM.
- dm_wdata  out  DATA_W  to DM.
- dm_we  out  1  to DM MemWrite.
- dm_re  out  1  to DM MemRead.
- dm_rdata  in  DATA_W  from DM.

Behaviour:
- FSM states: IDLE, LDR_BURST. Registers: state, beat_cnt (4b), starve_cnt (3b). Grants are combinational from state, requests and starve_cnt, and are mutually exclusive.
- IDLE arbitration:
  - cpu_req and (starve_cnt < STARVE_LIMIT or !ldr_req) -> cpu_gnt.
  - Otherwise, ldr_req -> ldr_gnt. Load beat_cnt = min(max(len,1),MAX_BURST)-1. Go to LDR_BURST if beat_cnt != 0, else stay in IDLE.
- LDR_BURST:
  - ldr_req high -> ldr_gnt; decrement beat_cnt; return to IDLE when beat_cnt hits 0.
  - ldr_req low -> no grant; abort burst to IDLE next edge, beat_cnt cleared.
  - cpu_gnt is always 0 in this state.
- starve_cnt:
  - Increments, saturating, each cycle ldr_req & !ldr_gnt.
  - Clears on any ldr_gnt or when ldr_req is low.
- DM mux:
  - cpu_gnt -> dm_* = cpu_* with dm_re = !cpu_we.
  - ldr_gnt -> dm_* = ldr_* with dm_re = !ldr_we.
  - No grant -> dm_we = 0, dm_re = 0, dm_addr = 0, dm_wdata = 0.
- Latency:
  - Grant is in the same cycle as the request when the port is free.
  - Writes commit at the next rising edge. Read data is combinational from DM in the granted cycle.
- Requester rule: hold req, addr, wdata and we stable until gnt is seen high; the access completes in that cycle.
- Reset (async, rst_n = 0):
  - state = IDLE, beat_cnt = 0, starve_cnt = 0.
  - All grants, dm_we and dm_re are 0 while rst_n is low.
  - Reset during a burst aborts the burst; no partial write after release.
- Simultaneous requests in IDLE with starve_cnt < STARVE_LIMIT: the CPU wins.

Optional Feature:
- DM_ARB_RR_EN defined:
  - IDLE arbitration is round-robin via a 1-bit last_owner register (reset = loader, so the CPU wins the first tie).
  - On a tie the port not served last wins. starve_cnt is unused and held at 0.
- Undefined: fixed CPU priority with the STARVE_LIMIT guard as above.

Test Plan:
- Reset, then cpu_req=1, cpu_we=1, addr=0x05, wdata=0xDEADBEEF, ldr_req=0 -> cpu_gnt=1, cpu_stall=0 same cycle; read at 0x05 the next cycle returns 0xDEADBEEF.
- ldr_req=1, len=3, cpu_req=0 -> ldr_gnt high for exactly 3 cycles. A cpu_req raised in cycle 2 sees cpu_stall=1 until cycle 4, then cpu_gnt.
- cpu_req and ldr_req held high continuously, len=1 -> the loader is denied 4 cycles (starve_cnt reaches 4), granted on the 5th, then the CPU resumes.
- Loader burst len=5, ldr_req dropped after beat 2 -> no further ldr_gnt; state is IDLE the next cycle; the CPU is granted immediately.
- len=0 -> a single beat; len=15 -> clamped to 8 beats.
- rst_n pulsed low mid-burst (beat 2 of 6) -> grants and dm_we drop asynchronously; after release the FSM is in IDLE with counters at 0.
